dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the data memory (byte/half/word store, sign/zero-extending load, combinational read, posedge write). Port A is the pipeline MEM stage (single accesses, any funct3). Port B is a DMA/debug engine issuing word bursts, which the arbiter sequences beat by beat. The core has priority, and a streak counter guarantees DMA forward progress.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter_dma_burst_seq.sv | 95 +++++++++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 tb/tb_dmem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents: memory access-size (funct3) encodings for loads and stores,
// the word-size code used for every DMA beat, and the burst sequencer
// state encoding.
package dmem_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // DMA always moves whole words.
  localparam logic [2:0] F3_DMA_WORD = F3_LW;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } burst_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core MEM stage, the DMA engine, the arbiter and
// the data memory.
//   slave  : arbiter view (takes requests, issues grants/responses,
//            drives the memory, receives memory read data)
//   master : environment view (requesters plus memory)
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  // core port
  logic                  core_req;
  logic                  core_we;
  logic [2:0]            core_funct3;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_wdata;
  logic                  core_gnt;
  logic                  core_rvalid;
  logic [DATA_WIDTH-1:0] core_rdata;
  // DMA port
  logic                  dma_start;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [LEN_WIDTH-1:0]  dma_len;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_beat_gnt;
  logic                  dma_rvalid;
  logic [DATA_WIDTH-1:0] dma_rdata;
  logic                  dma_busy;
  logic                  dma_done;
  // memory port
  logic                  mem_wr_en;
  logic [2:0]            mem_funct3;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport slave (
    input  core_req, core_we, core_funct3, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dma_start, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_beat_gnt, dma_rvalid, dma_rdata, dma_busy, dma_done,
    output mem_wr_en, mem_funct3, mem_addr, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output core_req, core_we, core_funct3, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dma_start, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_beat_gnt, dma_rvalid, dma_rdata, dma_busy, dma_done,
    input  mem_wr_en, mem_funct3, mem_addr, mem_wr_data,
    output mem_rd_data
  );

endinterface

// File: rtl/dmem_arbiter_dma_burst_seq.sv
// DMA burst sequencer: latches a burst descriptor on i_start (ignored while
// a burst is running), presents the current beat address/direction, steps
// address and beat count on every beat grant, and pulses o_done the cycle
// after the final beat.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_start/i_we/i_addr/i_len  descriptor (len = beats minus one)
//   i_beat_gnt         beat performed this cycle
//   o_busy             burst in progress
//   o_we, o_addr       current beat direction and byte address
//   o_done             one-cycle completion pulse
module dma_burst_seq
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_beat_gnt,
  output logic                  o_busy,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_done
);

  burst_state_e          r_state;
  burst_state_e          w_state_nxt;
  logic                  w_latch;
  logic                  w_step;
  logic                  w_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_we;
  logic                  r_done;

  assign w_last = (r_cnt == r_len);
  assign w_step = (r_state == ST_BURST) && i_beat_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_BURST;
          w_latch     = 1'b1;
        end
      end
      ST_BURST: begin
        // Leave in the same cycle the last beat is granted.
        if (i_beat_gnt && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_step && w_last;
      if (w_latch) begin
        r_addr <= i_addr;
        r_len  <= i_len;
        r_we   <= i_we;
        r_cnt  <= '0;
      end else if (w_step) begin
        // Natural modulo-2^ADDR_WIDTH wrap of the byte address.
        r_addr <= r_addr + ADDR_WIDTH'(4);
        r_cnt  <= r_cnt + LEN_WIDTH'(1);
      end
    end
  end

  assign o_busy = (r_state == ST_BURST);
  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_done = r_done;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the data memory.
// The core (MEM stage) has priority; the DMA engine gets a beat whenever the
// core is idle, or after MAX_CORE_STREAK consecutive core grants while a
// burst waits. Grants and the memory drive are combinational; load data is
// returned one cycle after the grant.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         dmem_arbiter_if.slave: core port, DMA port, memory port
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_CORE_STREAK = 4,
  parameter int LEN_WIDTH       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int                  STREAK_W   = $clog2(MAX_CORE_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CORE_STREAK);

  logic                  w_busy;
  logic                  w_burst_we;
  logic [ADDR_WIDTH-1:0] w_burst_addr;
  logic                  w_done;
  logic                  w_dma_gnt;
  logic                  w_core_gnt;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_core_rvalid;
  logic [DATA_WIDTH-1:0] r_core_rdata;
  logic                  r_dma_rvalid;
  logic [DATA_WIDTH-1:0] r_dma_rdata;

  dma_burst_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (bus.dma_start),
    .i_we       (bus.dma_we),
    .i_addr     (bus.dma_addr),
    .i_len      (bus.dma_len),
    .i_beat_gnt (w_dma_gnt),
    .o_busy     (w_busy),
    .o_we       (w_burst_we),
    .o_addr     (w_burst_addr),
    .o_done     (w_done)
  );

  // rst_n gates the grants so a held core request cannot reach the memory
  // while the block is in reset.
  assign w_dma_gnt  = rst_n && w_busy && (!bus.core_req || (r_streak >= STREAK_MAX));
  assign w_core_gnt = rst_n && bus.core_req && !w_dma_gnt;

  always_comb begin
    bus.mem_wr_en   = 1'b0;
    bus.mem_funct3  = 3'b000;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    if (w_core_gnt) begin
      bus.mem_wr_en   = bus.core_we;
      bus.mem_funct3  = bus.core_funct3;
      bus.mem_addr    = bus.core_addr;
      bus.mem_wr_data = bus.core_wdata;
    end else if (w_dma_gnt) begin
      bus.mem_wr_en   = w_burst_we;
      bus.mem_funct3  = F3_DMA_WORD;
      bus.mem_addr    = w_burst_addr;
      bus.mem_wr_data = bus.dma_wdata;
    end
  end

  // Counts core grants taken while a burst is waiting; reaching the limit
  // forces the next beat to DMA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (!w_busy || w_dma_gnt) begin
      r_streak <= '0;
    end else if (w_core_gnt && (r_streak < STREAK_MAX)) begin
      r_streak <= r_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rvalid <= 1'b0;
      r_core_rdata  <= '0;
      r_dma_rvalid  <= 1'b0;
      r_dma_rdata   <= '0;
    end else begin
      r_core_rvalid <= w_core_gnt && !bus.core_we;
      r_dma_rvalid  <= w_dma_gnt && !w_burst_we;
      if (w_core_gnt && !bus.core_we) r_core_rdata <= bus.mem_rd_data;
      if (w_dma_gnt && !w_burst_we)   r_dma_rdata  <= bus.mem_rd_data;
    end
  end

  assign bus.core_gnt     = w_core_gnt;
  assign bus.core_rvalid  = r_core_rvalid;
  assign bus.core_rdata   = r_core_rdata;
  assign bus.dma_beat_gnt = w_dma_gnt;
  assign bus.dma_rvalid   = r_dma_rvalid;
  assign bus.dma_rdata    = r_dma_rdata;
  assign bus.dma_busy     = w_busy;
  assign bus.dma_done     = w_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model
// (beats remaining, current burst address, core-streak count, byte memory).
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus();

  dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_CORE_STREAK(MAXS), .LEN_WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory environment (combinational read, posedge write)
  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];
  logic [7:0] env_a;

  function automatic logic [31:0] fmt_load(input logic [7:0] b0, b1, b2, b3,
                                           input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'h0, b0};
      3'b101:  return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) + 5);
  endfunction

  always_comb begin
    env_a = bus.mem_addr[7:0];
    bus.mem_rd_data = fmt_load(env_mem[env_a], env_mem[env_a + 8'd1],
                               env_mem[env_a + 8'd2], env_mem[env_a + 8'd3],
                               bus.mem_funct3);
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_byte(i);
    end else if (bus.mem_wr_en) begin
      env_mem[bus.mem_addr[7:0]] <= bus.mem_wr_data[7:0];
      if (bus.mem_funct3[1:0] != 2'b00)
        env_mem[bus.mem_addr[7:0] + 8'd1] <= bus.mem_wr_data[15:8];
      if (bus.mem_funct3[1:0] == 2'b10) begin
        env_mem[bus.mem_addr[7:0] + 8'd2] <= bus.mem_wr_data[23:16];
        env_mem[bus.mem_addr[7:0] + 8'd3] <= bus.mem_wr_data[31:24];
      end
    end
  end

  // ---------------- reference model
  logic        m_busy;
  logic        m_we;
  logic [31:0] m_addr;
  int          m_left;
  int          m_streak;
  logic        m_last_gc;
  logic        exp_core_rvalid, exp_dma_rvalid, exp_done;
  logic [31:0] exp_core_rdata, exp_dma_rdata;

  // values seen at the last check point, for directed checks
  logic        obs_cg, obs_dg, obs_crv, obs_drv, obs_done, obs_busy;
  logic [31:0] obs_crd, obs_drd, obs_maddr;
  logic [2:0]  obs_mf3;

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] i;
    i = a[7:0];
    return fmt_load(ref_mem[i], ref_mem[i + 8'd1], ref_mem[i + 8'd2], ref_mem[i + 8'd3], f3);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    logic [7:0] i;
    i = a[7:0];
    ref_mem[i] = d[7:0];
    if (f3[1:0] != 2'b00) ref_mem[i + 8'd1] = d[15:8];
    if (f3[1:0] == 2'b10) begin
      ref_mem[i + 8'd2] = d[23:16];
      ref_mem[i + 8'd3] = d[31:24];
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_we = 1'b0; m_addr = '0; m_left = 0; m_streak = 0;
    m_last_gc = 1'b0;
    exp_core_rvalid = 1'b0; exp_dma_rvalid = 1'b0; exp_done = 1'b0;
    exp_core_rdata = '0; exp_dma_rdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_funct3 = 3'b000;
    bus.core_addr = '0; bus.core_wdata = '0;
    bus.dma_start = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0;
    bus.dma_len = '0; bus.dma_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_core_gnt"}, bus.core_gnt, 1'b0);
    chk1({tag, "_dma_gnt"}, bus.dma_beat_gnt, 1'b0);
    chk1({tag, "_core_rvalid"}, bus.core_rvalid, 1'b0);
    chk1({tag, "_dma_rvalid"}, bus.dma_rvalid, 1'b0);
    chk1({tag, "_busy"}, bus.dma_busy, 1'b0);
    chk1({tag, "_done"}, bus.dma_done, 1'b0);
    chk1({tag, "_wr_en"}, bus.mem_wr_en, 1'b0);
    chk32({tag, "_core_rdata"}, bus.core_rdata, 32'h0);
    chk32({tag, "_dma_rdata"}, bus.dma_rdata, 32'h0);
    chk32({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
  endtask

  // One clock cycle: check at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic tick();
    logic gd, gc, e_we;
    logic [2:0] e_f3;
    logic [31:0] e_addr, e_wd, cload, dload;
    @(negedge clk);
    obs_cg = bus.core_gnt; obs_dg = bus.dma_beat_gnt;
    obs_crv = bus.core_rvalid; obs_crd = bus.core_rdata;
    obs_drv = bus.dma_rvalid; obs_drd = bus.dma_rdata;
    obs_done = bus.dma_done; obs_busy = bus.dma_busy;
    obs_maddr = bus.mem_addr; obs_mf3 = bus.mem_funct3;

    chk1("core_rvalid", bus.core_rvalid, exp_core_rvalid);
    chk32("core_rdata", bus.core_rdata, exp_core_rdata);
    chk1("dma_rvalid", bus.dma_rvalid, exp_dma_rvalid);
    chk32("dma_rdata", bus.dma_rdata, exp_dma_rdata);
    chk1("dma_done", bus.dma_done, exp_done);
    chk1("dma_busy", bus.dma_busy, m_busy);

    gd = m_busy && (!bus.core_req || m_streak >= MAXS);
    gc = bus.core_req && !gd;
    e_we = 1'b0; e_f3 = 3'b000; e_addr = '0; e_wd = '0;
    if (gc) begin
      e_we = bus.core_we; e_f3 = bus.core_funct3; e_addr = bus.core_addr; e_wd = bus.core_wdata;
    end else if (gd) begin
      e_we = m_we; e_f3 = 3'b010; e_addr = m_addr; e_wd = bus.dma_wdata;
    end
    chk1("core_gnt", bus.core_gnt, gc);
    chk1("dma_beat_gnt", bus.dma_beat_gnt, gd);
    chk1("mem_wr_en", bus.mem_wr_en, e_we);
    chk32("mem_funct3", {29'h0, bus.mem_funct3}, {29'h0, e_f3});
    chk32("mem_addr", bus.mem_addr, e_addr);
    chk32("mem_wr_data", bus.mem_wr_data, e_wd);

    cload = ref_load(bus.core_addr, bus.core_funct3);
    dload = ref_load(m_addr, 3'b010);
    exp_core_rvalid = gc && !bus.core_we;
    if (gc && !bus.core_we) exp_core_rdata = cload;
    exp_dma_rvalid = gd && !m_we;
    if (gd && !m_we) exp_dma_rdata = dload;
    if (e_we) ref_store(e_addr, e_f3, e_wd);

    if (!m_busy || gd) m_streak = 0;
    else if (gc && m_streak < MAXS) m_streak++;
    exp_done = gd && (m_left == 1);
    if (gd) begin
      m_addr = m_addr + 32'd4;
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end else if (!m_busy && bus.dma_start) begin
      m_busy = 1'b1; m_we = bus.dma_we; m_addr = bus.dma_addr;
      m_left = int'(bus.dma_len) + 1;
    end
    m_last_gc = gc;
    @(posedge clk);
    #1;
  endtask

  task automatic dma_kick(input logic we, input logic [31:0] a, input logic [7:0] len);
    bus.dma_start = 1'b1; bus.dma_we = we; bus.dma_addr = a; bus.dma_len = len;
    tick();
    bus.dma_start = 1'b0;
  endtask

  logic [2:0] ld_f3 [5];
  logic [2:0] st_f3 [3];

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    ld_f3 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    st_f3 = '{F3_SB, F3_SH, F3_SW};
    idle_inputs();
    model_reset();

    // reset state, with a core request held to confirm grants stay low
    repeat (3) @(posedge clk);
    #1 bus.core_req = 1'b1;
    #1 check_reset_outputs("por");
    bus.core_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // core store then load
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_funct3 = F3_SW;
    bus.core_addr = 32'h10; bus.core_wdata = 32'hDEADBEEF;
    tick();
    chk1("t1_store_gnt", obs_cg, 1'b1);
    bus.core_we = 1'b0; bus.core_funct3 = F3_LW;
    tick();
    chk1("t1_load_gnt", obs_cg, 1'b1);
    chk1("t1_no_rvalid_after_store", obs_crv, 1'b0);
    bus.core_req = 1'b0;
    tick();
    chk1("t1_rvalid", obs_crv, 1'b1);
    chk32("t1_rdata", obs_crd, 32'hDEADBEEF);

    // DMA write burst, 4 beats at 0x40
    dma_kick(1'b1, 32'h40, 8'd3);
    for (int i = 0; i < 4; i++) begin
      bus.dma_wdata = 32'hA5000000 + 32'(i);
      tick();
      chk1("t2_beat_gnt", obs_dg, 1'b1);
      chk32("t2_beat_addr", obs_maddr, 32'h40 + 32'(4 * i));
      chk32("t2_funct3", {29'h0, obs_mf3}, 32'h2);
    end
    tick();
    chk1("t2_done", obs_done, 1'b1);
    chk1("t2_busy_low", obs_busy, 1'b0);
    tick();
    chk1("t2_done_single", obs_done, 1'b0);

    // core priority over a pending beat, sign-extended byte load
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_funct3 = F3_SB;
    bus.core_addr = 32'h20; bus.core_wdata = 32'h00000080;
    tick();
    bus.core_req = 1'b0;
    dma_kick(1'b0, 32'h40, 8'd0);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = F3_LB;
    tick();
    chk1("t4_core_first", obs_cg, 1'b1);
    chk1("t4_dma_waits", obs_dg, 1'b0);
    bus.core_req = 1'b0;
    tick();
    chk1("t4_dma_next", obs_dg, 1'b1);
    chk1("t4_core_rvalid", obs_crv, 1'b1);
    chk32("t4_lb_sext", obs_crd, 32'hFFFFFF80);
    tick();
    chk1("t4_dma_rvalid", obs_drv, 1'b1);
    chk32("t4_dma_rdata", obs_drd, 32'hA5000000);
    chk1("t4_done", obs_done, 1'b1);

    // second dma_start mid-burst is ignored
    dma_kick(1'b1, 32'h80, 8'd3);
    for (int i = 0; i < 4; i++) begin
      bus.dma_wdata = 32'h5A000000 + 32'(i);
      if (i == 1) begin
        bus.dma_start = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'hC0; bus.dma_len = 8'd7;
      end
      tick();
      bus.dma_start = 1'b0;
      chk32("t6_beat_addr", obs_maddr, 32'h80 + 32'(4 * i));
    end
    tick();
    chk1("t6_done", obs_done, 1'b1);
    tick();
    chk1("t6_stays_idle", obs_busy, 1'b0);

    // starvation guard: 4 core, 1 DMA, 4 core, 1 DMA
    dma_kick(1'b0, 32'h10, 8'd1);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_funct3 = F3_LW; bus.core_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("t3_pattern", obs_dg, (i == 4) || (i == 9));
    end
    tick();
    chk1("t3_done", obs_done, 1'b1);
    bus.core_req = 1'b0;
    tick();

    // asynchronous reset mid-burst
    dma_kick(1'b0, 32'h60, 8'd7);
    tick();
    tick();
    bus.core_req = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_rst");
    model_reset();
    repeat (2) @(posedge clk);
    bus.core_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    chk1("t5_no_done", obs_done, 1'b0);
    dma_kick(1'b0, 32'h100, 8'd1);
    tick();
    chk1("t5_beat0_gnt", obs_dg, 1'b1);
    chk32("t5_beat0_addr", obs_maddr, 32'h100);
    tick();
    chk32("t5_beat1_addr", obs_maddr, 32'h104);
    tick();

    // random traffic, including bursts that wrap the top of the address space
    for (int n = 0; n < 800; n++) begin
      if (!bus.core_req || m_last_gc) begin
        bus.core_req = ($urandom_range(0, 99) < 60);
        bus.core_we = $urandom_range(0, 1) == 1;
        f3 = bus.core_we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
        a = $urandom;
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        bus.core_funct3 = f3; bus.core_addr = a; bus.core_wdata = $urandom;
      end
      bus.dma_start = ($urandom_range(0, 99) < 8);
      bus.dma_we = $urandom_range(0, 1) == 1;
      a = $urandom;
      a[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFFFFF0 + (32'($urandom_range(0, 3)) << 2);
      bus.dma_addr = a;
      bus.dma_len = 8'($urandom_range(0, 9));
      bus.dma_wdata = $urandom;
      tick();
    end
    idle_inputs();
    repeat (16) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
